halflife_input_cond: RTL and testbench
======================================

Name: halflife_input_cond

Overview:
Upstream conditioning stage for the half-life timer core. It takes raw asynchronous pad signals (up button, 3-bit mode switches, 4-bit value nibble) and delivers clean signals to the core's up/down/in inputs:
- a single-cycle up_pulse per debounced button press;
- debounced, glitch-free mode and value buses.

Parameters:
DEB_CYCLES, 50000, consecutive stable clock cycles required to accept a new input level (>=1)
DEB_W, 16, width of debounce counters; 2^DEB_W must be >= DEB_CYCLES
REP_DELAY, 25000000, cycles in HELD before the first auto-repeat pulse (optional feature only)
REP_PERIOD, 5000000, cycles between auto-repeat pulses (optional feature only)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
btn_raw  input  1  raw up button, asynchronous, may bounce
mode_raw  input  3  raw mode switches, asynchronous
val_raw  input  4  raw value nibble, asynchronous
up_pulse  output  1  one-cycle strobe per accepted press; feeds core up input
pressed  output  1  debounced button level
mode  output  3  debounced mode; feeds core down[2:0]
val  output  4  debounced value; feeds core in[3:0]

Behaviour:
- Reset:
  - Asynchronous reset on rst_n low; release is synchronous to clk.
  - Every flop, counter and output resets to 0; the button FSM resets to IDLE.
- Synchronizer:
  - Each of the 8 raw bits passes through a 2-flop synchronizer.
  - A raw change sampled at edge 0 is visible as sync at edge 2.
- Button FSM (states IDLE, DEB_ON, HELD, DEB_OFF; one counter bcnt):
  - IDLE: sync=1 -> DEB_ON, bcnt<=0.
  - DEB_ON: sync=0 -> IDLE. Else if bcnt==DEB_CYCLES-1 -> HELD. Else bcnt++.
  - HELD: sync=0 -> DEB_OFF, bcnt<=0.
  - DEB_OFF: sync=1 -> HELD, with no pulse. Else if bcnt==DEB_CYCLES-1 -> IDLE. Else bcnt++.
  - pressed is registered: 1 in HELD and DEB_OFF, 0 in IDLE and DEB_ON.
  - up_pulse is registered: high only in the single cycle following the DEB_ON->HELD transition.
  - Latency: raw rising edge at edge 0 -> up_pulse and pressed high after edge DEB_CYCLES+3.
- Bus debounce (mode and val as one 7-bit word; registers cand, bcnt2):
  - If sync word != cand: cand<=sync word, bcnt2<=0.
  - Else if bcnt2==DEB_CYCLES-1: {mode,val}<=cand; bcnt2 holds (saturates).
  - Else bcnt2++.
  - Any change during the count restarts it, so outputs never show an intermediate value.
  - Latency: DEB_CYCLES+3 edges from the last raw change.
- Boundary conditions:
  - DEB_CYCLES=1: a level is accepted after one stable cycle.
  - Counters never wrap.
  - A button held through reset release yields exactly one up_pulse, at DEB_CYCLES+3 edges after release.
  - Reset asserted mid-debounce: all outputs go to 0 immediately and no pulse is emitted.
  - Button and bus paths are fully independent; simultaneous changes on both are each handled normally.

Optional Feature:
HL_AUTOREPEAT_EN
- Defined: a repeat counter runs while in HELD and is cleared on any state other than HELD.
  - First extra up_pulse comes REP_DELAY cycles after the initial pulse.
  - Further pulses follow every REP_PERIOD cycles while still in HELD.
  - A DEB_OFF->HELD bounce return restarts the REP_DELAY wait.
- Undefined: one pulse per press only. The repeat logic is absent and REP_* are ignored.

Test Plan:
- Bench setting: DEB_CYCLES=4.
- Reset, all raw=0, run 20 cycles -> up_pulse=0, pressed=0, mode=0, val=0 throughout.
- btn_raw 0->1 at cycle 0, held 30 cycles -> up_pulse high exactly once, in cycle 7; pressed=1 from cycle 7.
- btn_raw high 3 cycles then low (glitch) -> no up_pulse; pressed stays 0.
- Button in HELD, btn_raw low 2 cycles then high -> pressed stays 1, no new up_pulse.
- Button in HELD, btn_raw low for 10 cycles -> pressed=0 after 7 cycles.
- mode_raw=3'b101 and val_raw=4'hA applied at cycle 0 -> mode=5 and val=A at cycle 7.
- Then toggle val_raw every 2 cycles -> mode and val unchanged.
- rst_n low at cycle 5 during DEB_ON -> all outputs 0 immediately.
- With HL_AUTOREPEAT_EN, REP_DELAY=8, REP_PERIOD=4, button held 30 cycles -> up_pulse at cycles 7, 15, 19, 23, 27.

Source files
------------

// File: rtl/halflife_input_cond.sv
// halflife_input_cond: synchronizes and debounces the raw up button, mode switches and value nibble
// for the half-life timer core. Optional auto-repeat of up_pulse while held: define HL_AUTOREPEAT_EN.
module halflife_input_cond #(
    parameter int DEB_CYCLES = 50000,
    parameter int DEB_W      = 16,
    parameter int REP_DELAY  = 25000000,
    parameter int REP_PERIOD = 5000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_raw,
    input  logic [2:0] mode_raw,
    input  logic [3:0] val_raw,
    output logic       up_pulse,
    output logic       pressed,
    output logic [2:0] mode,
    output logic [3:0] val
);

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DEB_ON  = 2'd1,
        HELD    = 2'd2,
        DEB_OFF = 2'd3
    } btn_state_e;

    // Bit 7 is the button, bits 6:4 mode, bits 3:0 value.
    logic [7:0]       meta_d, meta_q;
    logic [7:0]       sync_d, sync_q;
    logic             btn_sync;
    logic [6:0]       bus_sync;

    btn_state_e       state_d, state_q;
    logic [DEB_W-1:0] bcnt_d, bcnt_q;
    logic             pressed_d, pressed_q;
    logic             up_pulse_d, up_pulse_q;

    logic [6:0]       cand_d, cand_q;
    logic [DEB_W-1:0] bcnt2_d, bcnt2_q;
    logic [2:0]       mode_d, mode_q;
    logic [3:0]       val_d, val_q;

`ifdef HL_AUTOREPEAT_EN
    localparam int REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] REP_DELAY_LAST  = REP_W'(REP_DELAY - 1);
    localparam logic [REP_W-1:0] REP_PERIOD_LAST = REP_W'(REP_PERIOD - 1);

    logic [REP_W-1:0] rcnt_d, rcnt_q;
    logic             rep_first_d, rep_first_q;
`else
    // REP_* only shape the auto-repeat timer, which this build leaves out.
    if (REP_DELAY < 1 || REP_PERIOD < 1) begin : g_rep_unused
    end
`endif

    always_comb begin
        meta_d = {btn_raw, mode_raw, val_raw};
        sync_d = meta_q;
    end

    assign btn_sync = sync_q[7];
    assign bus_sync = sync_q[6:0];

    always_comb begin
        state_d    = state_q;
        bcnt_d     = bcnt_q;
        up_pulse_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (btn_sync) begin
                    state_d = DEB_ON;
                    bcnt_d  = '0;
                end
            end
            DEB_ON: begin
                if (!btn_sync) begin
                    state_d = IDLE;
                end else if (bcnt_q == DEB_LAST) begin
                    state_d    = HELD;
                    up_pulse_d = 1'b1;
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!btn_sync) begin
                    state_d = DEB_OFF;
                    bcnt_d  = '0;
                end
            end
            DEB_OFF: begin
                // A bounce back to 1 returns to HELD silently: the press was already reported.
                if (btn_sync) begin
                    state_d = HELD;
                end else if (bcnt_q == DEB_LAST) begin
                    state_d = IDLE;
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                bcnt_d  = '0;
            end
        endcase

`ifdef HL_AUTOREPEAT_EN
        // Any entry into HELD (press or bounce return) restarts the initial delay.
        rcnt_d      = '0;
        rep_first_d = 1'b1;
        if (state_q == HELD && state_d == HELD) begin
            if (rcnt_q == (rep_first_q ? REP_DELAY_LAST : REP_PERIOD_LAST)) begin
                up_pulse_d  = 1'b1;
                rep_first_d = 1'b0;
            end else begin
                rcnt_d      = rcnt_q + 1'b1;
                rep_first_d = rep_first_q;
            end
        end
`endif

        pressed_d = (state_d == HELD) || (state_d == DEB_OFF);
    end

    // Mode and value debounce as one word so the outputs can never show a torn mix.
    always_comb begin
        cand_d  = cand_q;
        bcnt2_d = bcnt2_q;
        mode_d  = mode_q;
        val_d   = val_q;
        if (bus_sync != cand_q) begin
            cand_d  = bus_sync;
            bcnt2_d = '0;
        end else if (bcnt2_q == DEB_LAST) begin
            {mode_d, val_d} = cand_q;
        end else begin
            bcnt2_d = bcnt2_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q     <= '0;
            sync_q     <= '0;
            state_q    <= IDLE;
            bcnt_q     <= '0;
            pressed_q  <= 1'b0;
            up_pulse_q <= 1'b0;
            cand_q     <= '0;
            bcnt2_q    <= '0;
            mode_q     <= '0;
            val_q      <= '0;
        end else begin
            meta_q     <= meta_d;
            sync_q     <= sync_d;
            state_q    <= state_d;
            bcnt_q     <= bcnt_d;
            pressed_q  <= pressed_d;
            up_pulse_q <= up_pulse_d;
            cand_q     <= cand_d;
            bcnt2_q    <= bcnt2_d;
            mode_q     <= mode_d;
            val_q      <= val_d;
        end
    end

`ifdef HL_AUTOREPEAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt_q      <= '0;
            rep_first_q <= 1'b1;
        end else begin
            rcnt_q      <= rcnt_d;
            rep_first_q <= rep_first_d;
        end
    end
`endif

    assign up_pulse = up_pulse_q;
    assign pressed  = pressed_q;
    assign mode     = mode_q;
    assign val      = val_q;

endmodule

// File: tb/tb_halflife_input_cond.sv
// Scoreboard bench for halflife_input_cond: run-length reference model feeds an expected queue,
// a negedge monitor pops and compares every cycle.
module tb_halflife_input_cond;

    localparam int DEB        = 4;
    localparam int REP_DELAY  = 8;
    localparam int REP_PERIOD = 4;

`ifdef HL_AUTOREPEAT_EN
    localparam int HOLD_PULSES = 5;
    localparam int HOLD_LAST   = 27;
    localparam int RST_PULSES  = 3;
`else
    localparam int HOLD_PULSES = 1;
    localparam int HOLD_LAST   = 7;
    localparam int RST_PULSES  = 1;
`endif

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       btn_raw  = 1'b0;
    logic [2:0] mode_raw = '0;
    logic [3:0] val_raw  = '0;
    logic       up_pulse;
    logic       pressed;
    logic [2:0] mode;
    logic [3:0] val;

    halflife_input_cond #(
        .DEB_CYCLES (DEB),
        .DEB_W      (16),
        .REP_DELAY  (REP_DELAY),
        .REP_PERIOD (REP_PERIOD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_raw  (btn_raw),
        .mode_raw (mode_raw),
        .val_raw  (val_raw),
        .up_pulse (up_pulse),
        .pressed  (pressed),
        .mode     (mode),
        .val      (val)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       up;
        logic       pr;
        logic [2:0] m;
        logic [3:0] v;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] hist[$];
    logic       lvl;
    int         run_cnt;
    int         held_age;
    logic [6:0] wcand;
    logic [6:0] wout;
    int         wrun;

    int checks = 0;
    int errors = 0;
    int obs_pulses = 0;
    int mon_cycles = 0;
    int last_pulse = -1;
    exp_t mon_e;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic void reset_model();
        hist.delete();
        lvl      = 1'b0;
        run_cnt  = 0;
        held_age = 0;
        wcand    = '0;
        wrun     = 1;
        wout     = '0;
    endfunction

    // A level (button) or word (bus) is taken once the synchronized input has differed from /
    // stayed at it for DEB+1 consecutive clock samples; the sync path delays raw by two edges.
    function automatic void model_edge();
        exp_t       e;
        logic [7:0] x;
        logic       was_held;
        logic       pulse;
        e = '0;
        if (!rst_n) begin
            reset_model();
            exp_q.push_back(e);
            return;
        end
        hist.push_back({btn_raw, mode_raw, val_raw});
        if (hist.size() > 3) void'(hist.pop_front());
        x = (hist.size() == 3) ? hist[0] : 8'h00;

        was_held = lvl && (run_cnt == 0);
        pulse    = 1'b0;
        if (x[7] != lvl) begin
            run_cnt++;
            if (run_cnt == DEB + 1) begin
                lvl      = x[7];
                run_cnt  = 0;
                pulse    = x[7];
                held_age = 0;
            end
        end else begin
            if (lvl && run_cnt != 0) begin
                held_age = 0;
            end else if (was_held) begin
                held_age++;
`ifdef HL_AUTOREPEAT_EN
                if (held_age >= REP_DELAY && ((held_age - REP_DELAY) % REP_PERIOD) == 0) pulse = 1'b1;
`endif
            end
            run_cnt = 0;
        end

        if (x[6:0] == wcand) begin
            if (wrun < DEB + 1) wrun++;
        end else begin
            wcand = x[6:0];
            wrun  = 1;
        end
        if (wrun >= DEB + 1) wout = wcand;

        e.up = pulse;
        e.pr = lvl;
        e.m  = wout[6:4];
        e.v  = wout[3:0];
        exp_q.push_back(e);
    endfunction

    // Raw inputs change 1 ns after each edge; the model records that edge first.
    task automatic applyStimulus(input logic b, input logic [2:0] m, input logic [3:0] v, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            model_edge();
            #1;
            btn_raw  = b;
            mode_raw = m;
            val_raw  = v;
        end
    endtask

    task automatic pulse_reset(input int cycles);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_up_pulse", 32'(up_pulse), 0);
        checkOutput("rst_pressed", 32'(pressed), 0);
        checkOutput("rst_mode", 32'(mode), 0);
        checkOutput("rst_val", 32'(val), 0);
        exp_q.delete();
        exp_q.push_back('0);
        reset_model();
        applyStimulus(btn_raw, mode_raw, val_raw, cycles);
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            if (up_pulse) begin
                obs_pulses++;
                last_pulse = mon_cycles;
            end
            checkOutput("up/pressed/mode/val", {23'd0, up_pulse, pressed, mode, val}, {23'd0, mon_e});
        end
        mon_cycles++;
    end

    initial begin
        int         p0;
        int         base;
        logic       b;
        logic [6:0] w;

        reset_model();
        applyStimulus(1'b0, 3'd0, 4'd0, 3);
        rst_n = 1'b1;
        applyStimulus(1'b0, 3'd0, 4'd0, 20);

        // Clean press held, then released.
        p0   = obs_pulses;
        base = mon_cycles + 1;
        applyStimulus(1'b1, 3'd0, 4'd0, 28);
        applyStimulus(1'b0, 3'd0, 4'd0, 15);
        checkOutput("hold_pulse_count", 32'(obs_pulses - p0), 32'(HOLD_PULSES));
        checkOutput("hold_last_pulse_cycle", 32'(last_pulse - base), 32'(HOLD_LAST));

        // Short glitch never becomes a press.
        p0 = obs_pulses;
        applyStimulus(1'b1, 3'd0, 4'd0, 3);
        applyStimulus(1'b0, 3'd0, 4'd0, 12);
        checkOutput("glitch_pulse_count", 32'(obs_pulses - p0), 0);

        // Bounce while held, then a full release.
        p0 = obs_pulses;
        applyStimulus(1'b1, 3'd0, 4'd0, 12);
        applyStimulus(1'b0, 3'd0, 4'd0, 2);
        applyStimulus(1'b1, 3'd0, 4'd0, 10);
`ifndef HL_AUTOREPEAT_EN
        checkOutput("bounce_pulse_count", 32'(obs_pulses - p0), 1);
`endif
        applyStimulus(1'b0, 3'd0, 4'd0, 10);

        // Bus settle, then val chatter that never stays long enough.
        applyStimulus(1'b0, 3'b101, 4'hA, 10);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 3'b101, (i % 2 == 0) ? 4'h3 : 4'hA, 2);
        end
        applyStimulus(1'b0, 3'd3, 4'd6, 10);

        // Reset in the middle of DEB_ON, button kept high through release.
        p0 = obs_pulses;
        applyStimulus(1'b1, 3'd3, 4'd6, 5);
        pulse_reset(3);
        checkOutput("mid_reset_pulse_count", 32'(obs_pulses - p0), 0);
        p0 = obs_pulses;
        applyStimulus(1'b1, 3'd3, 4'd6, 20);
        checkOutput("held_reset_pulse_count", 32'(obs_pulses - p0), 32'(RST_PULSES));
        applyStimulus(1'b0, 3'd3, 4'd6, 12);

        // Randomized traffic with occasional resets.
        b = 1'b0;
        w = '0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) b = ~b;
            if ($urandom_range(0, 7) == 0) w = 7'($urandom);
            applyStimulus(b, w[6:4], w[3:0], 1);
            if ($urandom_range(0, 499) == 0) pulse_reset(int'($urandom_range(1, 3)));
        end

        applyStimulus(1'b0, 3'd0, 4'd0, 12);
        @(negedge clk);
        #1;
        checkOutput("queue_drained", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
